// File: rtl/serial_adder.sv
// Bit-serial adder: accepts two WIDTH-bit operands, adds them one bit per
// clock LSB-first, then presents the registered sum and carry-out with a
// one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_out, last_bit;

  // Full adder on the current operand LSBs and the running carry
  assign s_bit    = a_sh[0] ^ b_sh[0] ^ cy;
  assign c_out    = (a_sh[0] & b_sh[0]) | (cy & (a_sh[0] ^ b_sh[0]));
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = ADD;
      ADD:     if (last_bit) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Working registers: load on accept, shift one bit per ADD cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh <= a;
          b_sh <= b;
          s_sh <= '0;
          cy   <= 1'b0;
          cnt  <= '0;
        end
        ADD: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          s_sh <= {s_bit, s_sh[WIDTH-1:1]};
          cy   <= c_out;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers update only on the edge that enters DONE, folding in
  // the final bit computed on that same edge so no partial value is seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      carry <= 1'b0;
    end else if (state == ADD && last_bit) begin
      sum   <= {s_bit, s_sh[WIDTH-1:1]};
      carry <= c_out;
    end
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);

endmodule
